// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, flag indices and sequencer enums for the 8-bit CPU
package cpu_pkg;

    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BN   = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    localparam int FLAG_Z = 5;
    localparam int FLAG_N = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_REL
    } pc_sel_t;

endpackage

// File: rtl/cpu_pc_unit.sv
// rtl/cpu_pc_unit.sv - program counter register with hold / +1 / +sext(offset) update
module cpu_pc_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  pc_sel_t           pc_sel,
    input  logic [3:0]        offset,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] offset_sext;

    // 4-bit two's-complement branch offset widened to the address width
    assign offset_sext = {{(ADDR_W-4){offset[3]}}, offset};

    // next-pc select; all arithmetic wraps modulo 2^ADDR_W
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_INC:  pc_d = pc_q + ADDR_W'(1);
            PC_REL:  pc_d = pc_q + offset_sext;
            default: pc_d = pc_q;
        endcase
    end

    // pc register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute/write-back control unit for the 8-bit CPU
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    input  logic [7:0]         sreg,
    output logic [ADDR_W-1:0]  pc,
    output logic               imem_en,
    output logic [3:0]         ir_opcode,
    output logic [3:0]         ir_r1,
    output logic [3:0]         ir_r2,
    output logic [3:0]         ir_r3,
    output logic               alu_en,
    output logic               rf_we,
    output logic               flag_we,
    output logic               halted
);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic               run_q;
    logic               run_d;
    pc_sel_t            pc_sel;
    logic               unused_sreg;

    // only Z and N steer branches; the other status bits are ignored here
    assign unused_sreg = ^{sreg[6], sreg[4:0]};

    assign ir_opcode = ir_q[15:12];
    assign ir_r1     = ir_q[11:8];
    assign ir_r2     = ir_q[7:4];
    assign ir_r3     = ir_q[3:0];
    assign run_d     = run;

    cpu_pc_unit #(
        .ADDR_W (ADDR_W)
    ) u_pc_unit (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc_sel (pc_sel),
        .offset (ir_r1),
        .pc     (pc)
    );

    // next state, IR load, pc select and strobes decoded from the current state
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_sel  = PC_HOLD;
        imem_en = 1'b0;
        alu_en  = 1'b0;
        rf_we   = 1'b0;
        flag_we = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_en = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!ir_opcode[3]) begin
                    alu_en  = 1'b1;
                    state_d = ST_WB;
                end else if (ir_opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    case (ir_opcode)
                        OP_JMP:  pc_sel = PC_REL;
                        OP_BZ:   pc_sel = sreg[FLAG_Z] ? PC_REL : PC_INC;
                        OP_BN:   pc_sel = sreg[FLAG_N] ? PC_REL : PC_INC;
                        default: pc_sel = PC_INC;
                    endcase
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                flag_we = 1'b1;
                pc_sel  = PC_INC;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
                // a level-high run must not restart; only a fresh 0->1 edge does
                if (run && !run_q) begin
                    pc_sel  = PC_INC;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, instruction register and previous-run registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard testbench for cpu_sequencer
module tb_cpu_sequencer;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_ALU   = 2'd1;
    localparam logic [1:0] K_WB    = 2'd2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run;
    logic [INSTR_W-1:0] instr;
    logic [7:0]         sreg;
    logic [ADDR_W-1:0]  pc;
    logic               imem_en;
    logic [3:0]         ir_opcode;
    logic [3:0]         ir_r1;
    logic [3:0]         ir_r2;
    logic [3:0]         ir_r3;
    logic               alu_en;
    logic               rf_we;
    logic               flag_we;
    logic               halted;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem[256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          alu_cyc = 0;
    time         t_mark;

    cpu_sequencer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .instr     (instr),
        .sreg      (sreg),
        .pc        (pc),
        .imem_en   (imem_en),
        .ir_opcode (ir_opcode),
        .ir_r1     (ir_r1),
        .ir_r2     (ir_r2),
        .ir_r3     (ir_r3),
        .alu_en    (alu_en),
        .rf_we     (rf_we),
        .flag_we   (flag_we),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // synchronous program memory: data valid the cycle after imem_en
    always @(posedge clk) begin
        if (imem_en) instr <= mem[pc];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [15:0] val);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d actual=%0h required=none", kind, val);
        end else begin
            e = sb_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                errors++;
                $display("FAIL event actual=kind%0d:%0h required=kind%0d:%0h", kind, val, e.kind, e.val);
            end
        end
    endtask

    // monitor: every strobe the DUT presents is matched against the scoreboard
    always @(negedge clk) begin
        logic [14:0] gap;
        cyc++;
        if (rst_n) begin
            if (imem_en) sb_check(K_FETCH, {8'h00, pc});
            if (alu_en) begin
                alu_cyc = cyc;
                sb_check(K_ALU, {ir_opcode, ir_r1, ir_r2, ir_r3});
            end
            if (rf_we) begin
                gap = 15'(cyc - alu_cyc);
                sb_check(K_WB, {gap, flag_we});
            end
        end
    end

    task automatic wait_fetch(input logic [7:0] addr);
        logic found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (imem_en === 1'b1 && pc === addr) found = 1'b1;
        end
        check($sformatf("wait_fetch_%0h", addr), {31'd0, found}, 32'd1);
    endtask

    task automatic wait_halt();
        logic found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (halted === 1'b1) found = 1'b1;
        end
        check("wait_halt", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic found;
        rst_n = 1'b0;
        run   = 1'b0;
        sreg  = 8'h00;
        instr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hB000;

        repeat (3) @(negedge clk);
        check("reset_pc", {24'd0, pc}, 32'd0);
        check("reset_ir", {16'd0, ir_opcode, ir_r1, ir_r2, ir_r3}, 32'd0);
        check("reset_strobes", {27'd0, imem_en, alu_en, rf_we, flag_we, halted}, 32'd0);

        // program A: ALU op, jump chain, BZ taken / not taken, BN taken, HALT
        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'h8700;
        mem[8'h08] = 16'h8700;
        mem[8'h0F] = 16'hB000;
        mem[8'h10] = 16'h8D00;
        mem[8'h0D] = 16'h8700;
        mem[8'h14] = 16'h8700;
        mem[8'h1B] = 16'h8500;
        mem[8'h20] = 16'h9400;
        mem[8'h24] = 16'h8C00;
        mem[8'h21] = 16'h8F00;

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_fetch", {31'd0, imem_en}, 32'd0);
        push(K_FETCH, 16'h0000);
        push(K_ALU,   16'h1234);
        push(K_WB,    16'h0003);
        push(K_FETCH, 16'h0001);
        push(K_FETCH, 16'h0008);
        push(K_FETCH, 16'h000F);
        push(K_FETCH, 16'h0010);
        push(K_FETCH, 16'h000D);
        push(K_FETCH, 16'h0014);
        push(K_FETCH, 16'h001B);
        push(K_FETCH, 16'h0020);
        push(K_FETCH, 16'h0024);
        push(K_FETCH, 16'h0020);
        push(K_FETCH, 16'h0021);
        push(K_FETCH, 16'h0020);
        push(K_FETCH, 16'h0024);
        run = 1'b1;
        @(negedge clk);
        check("fetch_cycle1", {31'd0, imem_en}, 32'd1);

        wait_fetch(8'h10);
        t_mark = $time;
        wait_fetch(8'h0D);
        check("jmp_latency", 32'($time - t_mark), 32'd30);

        wait_fetch(8'h20);
        sreg = 8'h20;
        wait_fetch(8'h20);
        sreg = 8'h00;
        wait_fetch(8'h21);
        mem[8'h20] = 16'hA400;
        mem[8'h24] = 16'hC000;
        wait_fetch(8'h20);
        sreg = 8'h80;
        wait_halt();
        check("halt_pc_a", {24'd0, pc}, 32'h24);
        check("queue_empty_a", 32'(sb_q.size()), 32'd0);

        // program B: wrap-around in both directions, then HALT at 0x05
        rst_n = 1'b0;
        run   = 1'b0;
        sreg  = 8'h00;
        repeat (2) @(negedge clk);
        mem[8'h00] = 16'h8800;
        mem[8'hF8] = 16'h8400;
        mem[8'hFC] = 16'h8700;
        mem[8'h03] = 16'h8C00;
        mem[8'hFF] = 16'hB000;
        mem[8'h05] = 16'hC000;
        mem[8'h06] = 16'h7ABC;
        mem[8'h07] = 16'h1111;
        rst_n = 1'b1;
        push(K_FETCH, 16'h0000);
        push(K_FETCH, 16'h00F8);
        push(K_FETCH, 16'h00FC);
        push(K_FETCH, 16'h0003);
        push(K_FETCH, 16'h00FF);
        push(K_FETCH, 16'h0000);
        push(K_FETCH, 16'h0005);
        run = 1'b1;
        wait_fetch(8'hF8);
        mem[8'h00] = 16'h8500;
        wait_halt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_hold", {23'd0, halted, pc}, {23'd0, 1'b1, 8'h05});
        end

        run = 1'b0;
        @(negedge clk);
        push(K_FETCH, 16'h0006);
        push(K_ALU,   16'h7ABC);
        push(K_WB,    16'h0003);
        run = 1'b1;
        @(negedge clk);
        check("resume_fetch", {23'd0, imem_en, pc}, {23'd0, 1'b1, 8'h06});

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (alu_en === 1'b1) found = 1'b1;
        end
        check("wait_alu", {31'd0, found}, 32'd1);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("park_idle_pc", {24'd0, pc}, 32'h07);
        repeat (3) @(negedge clk);
        check("park_idle_strobes", {27'd0, imem_en, alu_en, rf_we, flag_we, halted}, 32'd0);

        push(K_FETCH, 16'h0007);
        run = 1'b1;
        wait_fetch(8'h07);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", {24'd0, pc}, 32'd0);
        check("async_reset_ir", {16'd0, ir_opcode, ir_r1, ir_r2, ir_r3}, 32'd0);
        check("async_reset_strobes", {27'd0, imem_en, alu_en, rf_we, flag_we, halted}, 32'd0);
        check("queue_empty_b", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 8-bit CPU. It owns the program counter, drives the 256×16 program memory, and latches each instruction word into an instruction register. It then sequences the register file, ALU and flag register through fixed fetch/decode/execute/write-back phases. Jump, branch and halt opcodes are resolved here; the ALU and register file only act on the enables this block issues.

## Interface
- `ADDR_W`, default 8, program-counter / memory address width.
- `INSTR_W`, default 16, instruction width: `[15:12]` opcode, `[11:8]` r1, `[7:4]` r2, `[3:0]` r3.
- `clk  in  1` — system clock; all state updates on the rising edge.
- `rst_n  in  1` — reset; asynchronous, active-low.
- `run  in  1` — level; 1 lets the sequencer leave IDLE or HALT.
- `instr  in  INSTR_W` — program memory read data; valid the cycle after `imem_en`.
- `sreg  in  8` — status register; bit 5 = Z, bit 7 = N.
- `pc  out  ADDR_W` — program memory address.
- `imem_en  out  1` — memory read strobe.
- `ir_opcode`, `ir_r1`, `ir_r2`, `ir_r3  out  4` each — instruction register fields.
- `alu_en  out  1` — ALU evaluate strobe.
- `rf_we  out  1` — register file write strobe.
- `flag_we  out  1` — status register write strobe.
- `halted  out  1` — 1 while in HALT.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, WB, HALT.
- **IDLE**
  - With `run`=1, go to FETCH.
  - With `run`=0, stay in IDLE.
- **FETCH:** `imem_en`=1, `pc` presented; go to DECODE.
- **DECODE:** latch `instr` into the IR fields; go to EXEC.
- **EXEC:** action depends on the opcode.
  - 0x0–0x7 (ALU): `alu_en`=1; go to WB.
  - 0x8 JMP: `pc += sext(r1)`.
  - 0x9 BZ: `pc += sext(r1)` if `sreg[5]`, else `pc+1`.
  - 0xA BN: `pc += sext(r1)` if `sreg[7]`, else `pc+1`.
  - 0xB and 0xD–0xF: NOP, `pc+1`.
  - 0xC HALT: `pc` unchanged; go to HALT.
  - Control opcodes other than HALT: go to FETCH if `run`, else IDLE.
- **WB:** `rf_we`=1, `flag_we`=1, `pc+1`; go to FETCH if `run`, else IDLE.
- **HALT:** `halted`=1.
  - Exit only on a rising edge of `run` (0 in the previous cycle, 1 now). The exit sets `pc+1` and goes to FETCH.
  - A `run` held at 1 does not exit HALT.
- **Arithmetic**
  - `sext(r1)` is the 4-bit two's-complement offset sign-extended to `ADDR_W`, giving a range of −8..+7.
  - All `pc` arithmetic is modulo 2^ADDR_W: 0xFF+1 = 0x00, and 0x02+(−8) = 0xFA.
- **run deassert:** dropping `run` mid-instruction never aborts it. The instruction completes and the sequencer parks in IDLE with `pc` already advanced.
- **Reset values:** state IDLE, `pc`=0, IR fields=0, and all strobes and `halted` at 0.

## Timing
- All strobes are registered-state decodes: combinational from the state register, each asserted for exactly one cycle per instruction.
- **Latency:** ALU instructions take 4 cycles (FETCH..WB); control instructions take 3 (FETCH..EXEC). The new `pc` is visible in the cycle after EXEC or WB.
- **Branch flags:** `sreg` is sampled in EXEC. The previous ALU instruction's `flag_we` in WB therefore always precedes the test, with no hazard.
- **Reset mid-instruction:** `rst_n` low returns the block immediately to IDLE with reset values. No strobe may glitch high during reset.
- **Resume from HALT:** the first FETCH follows the cycle in which the `run` rising edge is seen.

## Structure
- **Shared package `cpu_pkg`:**
  - Opcode constants: `OP_JMP`=4'h8, `OP_BZ`=4'h9, `OP_BN`=4'hA, `OP_NOP`=4'hB, `OP_HALT`=4'hC.
  - Flag bit indices: `FLAG_Z`=5, `FLAG_N`=7.
  - State enum `seq_state_t`.
- **Sub-module `cpu_pc_unit`:** holds the `pc` register and selects hold / +1 / +sext(r1). The FSM stays in `cpu_sequencer`.

## Test plan
- Reset, then `run`=1 with mem[0]=16'h1234 → `imem_en` in cycle 1; IR=1,2,3,4 after DECODE; `alu_en` then `rf_we`/`flag_we` in consecutive cycles; `pc`=0x01 after WB.
- JMP with `pc`=0x10 and mem[0x10]=16'h8D00 (offset −3) → `pc`=0x0D after 3 cycles; no `rf_we`.
- BZ at `pc`=0x20 with r1=4, run twice: `sreg`=8'h20 → `pc`=0x24; `sreg`=8'h00 → `pc`=0x21. BN at `pc`=0x20 with r1=4 and `sreg`=8'h80 → `pc`=0x24.
- Wrap-around: NOP at 0xFF → `pc`=0x00; JMP +7 at 0xFC → `pc`=0x03.
- HALT at 0x05 → `halted`=1 and `pc`=0x05 for 20 cycles with `run` held at 1. Drop then raise `run` → FETCH at 0x06.
- Drop `run` during EXEC of an ALU op → WB still issued, then IDLE. Assert `rst_n`=0 mid-DECODE → `pc`=0 and all strobes 0 asynchronously.
